// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    EXE_MULDIV_MULT  = 2'b00,
    EXE_MULDIV_MULTU = 2'b01,
    EXE_MULDIV_DIV   = 2'b10,
    EXE_MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic op_is_signed(input muldiv_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// One restoring-division step: shifted partial remainder minus divisor if it fits.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   part,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff     = part - {1'b0, divisor};
    q_bit    = (part >= {1'b0, divisor});
    rem_next = q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a HI/LO pair; stalls execute while busy.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      MUL_BITS    = 4,
  parameter logic [WIDTH-1:0] DIV_ZERO_LO = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned DW        = 2 * WIDTH;
  localparam int unsigned MUL_ITERS = WIDTH / MUL_BITS;
  localparam int unsigned CNT_W     = $clog2(WIDTH);

  muldiv_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [DW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_res_q, neg_rem_q, is_div_q, div_zero_q;

  logic             launch, op_signed, mul_last, div_last;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [DW-1:0]    mul_part, mul_sum, prod_fix;
  logic [31:0]      mul_sh;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] fix_hi, fix_lo, final_hi, final_lo;

  // Operand conditioning: signed ops work on magnitudes
  always_comb begin
    launch    = (state_q == ST_IDLE) && start_i && !cancel_i;
    op_signed = op_is_signed(muldiv_op_e'(op_i));
    abs_a     = (op_signed && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    abs_b     = (op_signed && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    mul_last  = (cnt_q == CNT_W'(MUL_ITERS - 1));
    div_last  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Multiplier step: LSB-first chunk of the multiplicand, shifted into place
  always_comb begin
    mul_part = DW'(b_q) * DW'(a_q[MUL_BITS-1:0]);
    mul_sh   = 32'(cnt_q) * MUL_BITS;
    mul_sum  = acc_q + (mul_part << mul_sh);
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .part     ({acc_q[DW-1:WIDTH], acc_q[WIDTH-1]}),
    .divisor  (b_q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  // Sign fix-up; the divide-by-zero LO pattern is never negated
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    fix_lo   = (neg_res_q && !div_zero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_hi   = neg_rem_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
    final_hi = is_div_q ? fix_hi : prod_fix[DW-1:WIDTH];
    final_lo = is_div_q ? fix_lo : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = op_i[1] ? ST_DIV : ST_MUL;
      ST_MUL: begin
        if (cancel_i)      state_d = ST_IDLE;
        else if (mul_last) state_d = ST_FIX;
      end
      ST_DIV: begin
        if (cancel_i)                       state_d = ST_IDLE;
        else if (b_q == '0 || div_last)     state_d = ST_FIX;
      end
      ST_FIX:  state_d = cancel_i ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall drops in DONE so the held instruction retires alongside done_o
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    stall_o = launch || (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (launch) begin
          a_q        <= abs_a;
          b_q        <= abs_b;
          cnt_q      <= '0;
          is_div_q   <= op_i[1];
          div_zero_q <= 1'b0;
          neg_res_q  <= op_signed & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
          neg_rem_q  <= op_signed & op_i[1] & opa_i[WIDTH-1];
          acc_q      <= op_i[1] ? {WIDTH'(0), abs_a} : '0;
        end
        ST_MUL: begin
          acc_q <= mul_sum;
          a_q   <= a_q >> MUL_BITS;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_DIV: begin
          if (b_q == '0) begin
            acc_q      <= {acc_q[WIDTH-1:0], DIV_ZERO_LO};
            div_zero_q <= 1'b1;
          end else begin
            acc_q <= {rem_nxt, acc_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers load on entry to DONE and hold until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= (state_q == ST_FIX) && !cancel_i;
      if ((state_q == ST_FIX) && !cancel_i) begin
        hi_o <= final_hi;
        lo_o <= final_lo;
      end
    end
  end

endmodule
